shift_pipe_arbiter: RTL
=======================

// Module: shift_pipe_arbiter
// PURPOSE
//   Shares one DEPTH-stage shift pipeline (stage k <= stage k-1 each clk) between
//   two requesters. Round-robin grant selects which requester's word enters
//   stage 0. A valid bit and owner tag travel with each word. The output stage
//   reports data, valid and owner, so consumers demux by tag.
// PARAMETERS
//   WIDTH  8  data bits per word
//   DEPTH  2  pipeline stages (>=1); sets input-to-output latency
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      async reset, active low
//   req0       in   1      requester 0 has a word this cycle
//   data0      in   WIDTH  requester 0 word
//   gnt0       out  1      req0 accepted this cycle (combinational)
//   req1       in   1      requester 1 has a word this cycle
//   data1      in   WIDTH  requester 1 word
//   gnt1       out  1      req1 accepted this cycle (combinational)
//   flush      in   1      sync flush: invalidate all stages
//   out_valid  out  1      last stage holds a valid word
//   out_tag    out  1      owner of last-stage word (0/1)
//   out_data   out  WIDTH  last-stage word
//   busy       out  1      any stage valid
// BEHAVIOUR
//   - Reset (rst_n=0, async): all stage valid/tag/data = 0; last_gnt = 1
//     (requester 0 wins first tie). out_valid=0, out_tag=0, out_data=0, busy=0.
//     gnt0/gnt1 = 0 while rst_n=0. Reset mid-stream discards in-flight words.
//   - Pipeline always advances; no stall. Each posedge: stage k <= stage k-1
//     (valid, tag, data), k=1..DEPTH-1.
//   - Grant (combinational, same cycle as req): flush=1 -> no grant.
//     Only req0 -> gnt0. Only req1 -> gnt1. Both -> grant the requester
//     != last_gnt. Neither -> no grant. At most one gnt high.
//   - Stage 0 at posedge: granted -> valid=1, tag=id, data=granted data;
//     no grant -> valid=0, tag/data hold previous value (don't care).
//   - last_gnt updates only on a grant; idle cycles keep it.
//   - Latency: word granted in cycle t appears at output in cycle t+DEPTH.
//   - flush=1 at posedge: all valid bits <= 0 the next cycle; tag/data may
//     keep stale values. flush dominates a simultaneous req.
//   - Non-granted requester must hold req/data; no internal queue.
//   - busy = OR of all stage valid bits (registered state, no input path).
// CONFIGURATION
//   ARB_STATS_EN defined: add outputs cnt0, cnt1 (16 bits each). Each counts
//     grants to its requester and saturates at 16'hFFFF. They clear on reset
//     only; flush does not clear them.
//   ARB_STATS_EN undefined: no counter ports or logic. Grant and pipeline
//     behaviour are identical in both builds.
// TESTING (WIDTH=8, DEPTH=2)
//   1 Reset: rst_n=0 mid-stream with valid words -> outputs 0 immediately;
//     after release, req0=req1=1 -> gnt0=1 first.
//   2 Single: req0=1, data0=8'hA5 in cycle 0 only -> cycle 2 out_valid=1,
//     out_tag=0, out_data=8'hA5; cycle 3 out_valid=0.
//   3 Round robin: req0=req1=1 held 4 cycles (data0=8'h10+n, data1=8'h20+n)
//     -> grants 0,1,0,1; output 10,21,12,23 with tags 0,1,0,1 from cycle 2.
//   4 Flush: fill both stages; flush=1 with req1=1 -> gnt1=0; next cycle
//     out_valid=0 and busy=0.
//   5 Idle keeps turn: gnt1 granted; idle 3 cycles; then req0=req1=1 -> gnt0=1.
//   6 ARB_STATS_EN: 5 grants to req0, 2 to req1 -> cnt0=5, cnt1=2; flush leaves
//     them unchanged; preload cnt0=16'hFFFF, grant req0 -> cnt0 stays 16'hFFFF.

Source files
------------

// File: rtl/shift_pipe_arbiter.sv
// Two-requester round-robin arbiter feeding a DEPTH-stage shift pipeline tagged with the owner id.
// Optional per-requester saturating grant counters (cnt0/cnt1) are built when ARB_STATS_EN is defined.
module shift_pipe_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt1,
    input  logic             flush,
    output logic             out_valid,
    output logic             out_tag,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
`endif
);

    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] tag_reg;
    logic [WIDTH-1:0] data_reg [DEPTH];

    logic [DEPTH-1:0] valid_next;
    logic [DEPTH-1:0] tag_next;
    logic [WIDTH-1:0] data_next [DEPTH];

    // Id of the most recent grant; on a tie the other requester wins.
    logic last_gnt_reg;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && !flush) begin
            if (req0 && req1) begin
                gnt0 = last_gnt_reg;
                gnt1 = !last_gnt_reg;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // Stage 0 loads the granted word; without a grant only its valid bit drops.
    always_comb begin
        valid_next[0] = gnt0 | gnt1;
        tag_next[0]   = tag_reg[0];
        data_next[0]  = data_reg[0];
        if (gnt1) begin
            tag_next[0]  = 1'b1;
            data_next[0] = data1;
        end else if (gnt0) begin
            tag_next[0]  = 1'b0;
            data_next[0] = data0;
        end
    end

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
            assign valid_next[gi] = valid_reg[gi-1] & ~flush;
            assign tag_next[gi]   = tag_reg[gi-1];
            assign data_next[gi]  = data_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg    <= '0;
            tag_reg      <= '0;
            last_gnt_reg <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i] <= '0;
            end
        end else begin
            valid_reg <= valid_next;
            tag_reg   <= tag_next;
            data_reg  <= data_next;
            if (gnt0 || gnt1) begin
                last_gnt_reg <= gnt1;
            end
        end
    end

    assign out_valid = valid_reg[DEPTH-1];
    assign out_tag   = tag_reg[DEPTH-1];
    assign out_data  = data_reg[DEPTH-1];
    assign busy      = |valid_reg;

`ifdef ARB_STATS_EN
    logic [15:0] cnt0_reg;
    logic [15:0] cnt1_reg;

    // Counters saturate rather than wrap; flush deliberately leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_reg <= '0;
            cnt1_reg <= '0;
        end else begin
            if (gnt0 && cnt0_reg != 16'hFFFF) begin
                cnt0_reg <= cnt0_reg + 16'd1;
            end
            if (gnt1 && cnt1_reg != 16'hFFFF) begin
                cnt1_reg <= cnt1_reg + 16'd1;
            end
        end
    end

    assign cnt0 = cnt0_reg;
    assign cnt1 = cnt1_reg;
`endif

endmodule
